// File: rtl/hazard3_example_soc.sv
// Board I/O shell for the Tang Nano 20K example SoC: boot banner on the UART,
// button-driven counter on the LEDs and a MAX7219 display, other peripherals parked idle.
module hazard3_example_soc #(
  parameter int unsigned UART_DIV = 234,
  parameter int unsigned SPI_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tck,
  input  logic        trst_n,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic        w_rxd,
  output logic        w_txd,
  output logic        O_sdram_clk,
  output logic        O_sdram_cke,
  output logic        O_sdram_cs_n,
  output logic        O_sdram_ras_n,
  output logic        O_sdram_cas_n,
  output logic        O_sdram_wen_n,
  output logic [10:0] O_sdram_addr,
  output logic [1:0]  O_sdram_ba,
  output logic [3:0]  O_sdram_dqm,
  inout  wire  [31:0] IO_sdram_dq,
  output logic [5:0]  w_led,
  input  logic        w_btnl,
  input  logic        w_btnr,
  output logic        sdcard_pwr_n,
  output logic        sdclk,
  inout  wire         sdcmd,
  input  logic        sddat0,
  output logic        sddat1,
  output logic        sddat2,
  output logic        sddat3,
  output logic        MAX7219_CLK,
  output logic        MAX7219_DATA,
  output logic        MAX7219_LOAD
);

  localparam int unsigned UDW = $clog2(UART_DIV + 1);
  localparam int unsigned SDW = $clog2(2 * SPI_DIV + 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} spi_state_e;

  // Parked peripherals
  assign tdo           = 1'b0;
  assign O_sdram_clk   = 1'b0;
  assign O_sdram_cke   = 1'b0;
  assign O_sdram_cs_n  = 1'b1;
  assign O_sdram_ras_n = 1'b1;
  assign O_sdram_cas_n = 1'b1;
  assign O_sdram_wen_n = 1'b1;
  assign O_sdram_addr  = '0;
  assign O_sdram_ba    = '0;
  assign O_sdram_dqm   = 4'hF;
  assign IO_sdram_dq   = 'z;
  assign sdcard_pwr_n  = 1'b1;
  assign sdclk         = 1'b0;
  assign sdcmd         = 1'bz;
  assign sddat1        = 1'b1;
  assign sddat2        = 1'b1;
  assign sddat3        = 1'b1;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, tck, trst_n, tms, tdi, uart_rx, w_rxd, sddat0};

  // Buttons: [0],[1] synchronizer, [2] previous synchronized level
  logic [2:0] btnl_q, btnr_q;
  logic       btnl_rise, btnr_rise;
  logic [5:0] count_q, count_d;
  logic [5:0] led_q;

  assign btnl_rise = btnl_q[1] & ~btnl_q[2];
  assign btnr_rise = btnr_q[1] & ~btnr_q[2];

  always_comb begin
    count_d = count_q;
    if (btnl_rise) count_d = count_q + 6'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnl_q  <= '0;
      btnr_q  <= '0;
      count_q <= '0;
      led_q   <= 6'h3F;
    end else begin
      btnl_q  <= {btnl_q[1:0], w_btnl};
      btnr_q  <= {btnr_q[1:0], w_btnr};
      count_q <= count_d;
      led_q   <= ~count_d;
    end
  end

  assign w_led = led_q;

  // UART banner transmitter
  uart_state_e    u_state_q, u_state_d;
  logic [UDW-1:0] u_div_q, u_div_d;
  logic [2:0]     u_bit_q, u_bit_d;
  logic [2:0]     u_byte_q, u_byte_d;
  logic           tx_q, tx_d;
  logic           boot_q, boot_d;
  logic           pend_q, pend_d;
  logic           u_consume;
  logic           u_tick;
  logic [7:0]     cur_byte;

  function automatic logic [7:0] banner_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h48;
      3'd1:    return 8'h5A;
      3'd2:    return 8'h33;
      3'd3:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign u_tick   = (u_div_q == UDW'(UART_DIV - 1));
  assign cur_byte = banner_byte(u_byte_q);

  always_comb begin
    u_state_d = u_state_q;
    u_div_d   = u_div_q;
    u_bit_d   = u_bit_q;
    u_byte_d  = u_byte_q;
    tx_d      = tx_q;
    u_consume = 1'b0;
    if (u_state_q != U_IDLE) u_div_d = u_tick ? '0 : u_div_q + UDW'(1);
    unique case (u_state_q)
      U_IDLE: begin
        tx_d = 1'b1;
        if (boot_q | pend_q) begin
          u_consume = 1'b1;
          u_state_d = U_START;
          u_byte_d  = '0;
          u_div_d   = '0;
          tx_d      = 1'b0;
        end
      end
      U_START: begin
        if (u_tick) begin
          u_state_d = U_DATA;
          u_bit_d   = '0;
          tx_d      = cur_byte[0];
        end
      end
      U_DATA: begin
        if (u_tick) begin
          if (u_bit_q == 3'd7) begin
            u_state_d = U_STOP;
            tx_d      = 1'b1;
          end else begin
            u_bit_d = u_bit_q + 3'd1;
            tx_d    = cur_byte[u_bit_q + 3'd1];
          end
        end
      end
      U_STOP: begin
        // A pending resend chains straight into the next start bit
        if (u_tick) begin
          if (u_byte_q != 3'd4) begin
            u_byte_d  = u_byte_q + 3'd1;
            u_state_d = U_START;
            tx_d      = 1'b0;
          end else if (boot_q | pend_q) begin
            u_consume = 1'b1;
            u_byte_d  = '0;
            u_state_d = U_START;
            tx_d      = 1'b0;
          end else begin
            u_state_d = U_IDLE;
            tx_d      = 1'b1;
          end
        end
      end
      default: u_state_d = U_IDLE;
    endcase
  end

  assign pend_d = (pend_q & ~u_consume) | btnr_rise;
  assign boot_d = boot_q & ~u_consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_state_q <= U_IDLE;
      u_div_q   <= '0;
      u_bit_q   <= '0;
      u_byte_q  <= '0;
      tx_q      <= 1'b1;
      boot_q    <= 1'b1;
      pend_q    <= 1'b0;
    end else begin
      u_state_q <= u_state_d;
      u_div_q   <= u_div_d;
      u_bit_q   <= u_bit_d;
      u_byte_q  <= u_byte_d;
      tx_q      <= tx_d;
      boot_q    <= boot_d;
      pend_q    <= pend_d;
    end
  end

  assign uart_tx = tx_q;
  assign w_txd   = tx_q;

  // MAX7219 word sequencer: indices 0-4 init, 5-12 digits 1..8
  spi_state_e     s_state_q, s_state_d;
  logic [SDW-1:0] s_cnt_q, s_cnt_d;
  logic [3:0]     s_bit_q, s_bit_d;
  logic [3:0]     s_idx_q, s_idx_d;
  logic [15:0]    s_sh_q, s_sh_d;
  logic           sclk_q, sclk_d;
  logic           sdat_q, sdat_d;
  logic           sload_q, sload_d;
  logic           s_start;
  logic [15:0]    next_word;

  function automatic logic [15:0] disp_word(input logic [3:0] idx, input logic [5:0] cnt);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = 4'(cnt % 6'd10);
    tens = 4'(cnt / 6'd10);
    case (idx)
      4'd0:    return 16'h0F00;
      4'd1:    return 16'h09FF;
      4'd2:    return 16'h0A08;
      4'd3:    return 16'h0B07;
      4'd4:    return 16'h0C01;
      4'd5:    return {8'h01, 4'h0, ones};
      4'd6:    return {8'h02, (cnt < 6'd10) ? 8'h0F : {4'h0, tens}};
      default: return {4'h0, idx - 4'd4, 8'h0F};
    endcase
  endfunction

  assign next_word = disp_word(s_idx_q, count_q);

  always_comb begin
    s_state_d = s_state_q;
    s_cnt_d   = s_cnt_q;
    s_bit_d   = s_bit_q;
    s_idx_d   = s_idx_q;
    s_sh_d    = s_sh_q;
    sclk_d    = sclk_q;
    sdat_d    = sdat_q;
    sload_d   = sload_q;
    s_start   = 1'b0;
    unique case (s_state_q)
      S_IDLE: s_start = 1'b1;
      S_LOW: begin
        if (s_cnt_q == SDW'(SPI_DIV - 1)) begin
          s_cnt_d   = '0;
          sclk_d    = 1'b1;
          s_state_d = S_HIGH;
        end else begin
          s_cnt_d = s_cnt_q + SDW'(1);
        end
      end
      S_HIGH: begin
        if (s_cnt_q == SDW'(SPI_DIV - 1)) begin
          s_cnt_d = '0;
          sclk_d  = 1'b0;
          if (s_bit_q == 4'd15) begin
            sload_d   = 1'b1;
            sdat_d    = 1'b0;
            s_state_d = S_GAP;
          end else begin
            s_bit_d   = s_bit_q + 4'd1;
            s_sh_d    = {s_sh_q[14:0], 1'b0};
            sdat_d    = s_sh_q[14];
            s_state_d = S_LOW;
          end
        end else begin
          s_cnt_d = s_cnt_q + SDW'(1);
        end
      end
      S_GAP: begin
        if (s_cnt_q == SDW'(2 * SPI_DIV - 1)) s_start = 1'b1;
        else                                 s_cnt_d = s_cnt_q + SDW'(1);
      end
      default: s_state_d = S_IDLE;
    endcase
    // Count is sampled here, as the word enters the shift register
    if (s_start) begin
      s_sh_d    = next_word;
      sdat_d    = next_word[15];
      sload_d   = 1'b0;
      sclk_d    = 1'b0;
      s_cnt_d   = '0;
      s_bit_d   = '0;
      s_idx_d   = (s_idx_q == 4'd12) ? 4'd5 : s_idx_q + 4'd1;
      s_state_d = S_LOW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_state_q <= S_IDLE;
      s_cnt_q   <= '0;
      s_bit_q   <= '0;
      s_idx_q   <= '0;
      s_sh_q    <= '0;
      sclk_q    <= 1'b0;
      sdat_q    <= 1'b0;
      sload_q   <= 1'b1;
    end else begin
      s_state_q <= s_state_d;
      s_cnt_q   <= s_cnt_d;
      s_bit_q   <= s_bit_d;
      s_idx_q   <= s_idx_d;
      s_sh_q    <= s_sh_d;
      sclk_q    <= sclk_d;
      sdat_q    <= sdat_d;
      sload_q   <= sload_d;
    end
  end

  assign MAX7219_CLK  = sclk_q;
  assign MAX7219_DATA = sdat_q;
  assign MAX7219_LOAD = sload_q;

endmodule

// File: tb/tb_hazard3_example_soc.sv
// Directed bench for hazard3_example_soc: banner framing, resend chaining,
// button counter/LEDs, MAX7219 word stream and reset behaviour.
module tb_hazard3_example_soc;

  localparam int unsigned UDIV       = 4;
  localparam int unsigned SDIV       = 1;
  localparam int unsigned BANNER_CYC = 50 * UDIV;
  localparam int unsigned LOOP_CYC   = 13 * 34 * SDIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w_btnl = 1'b0;
  logic w_btnr = 1'b0;
  logic tdo, uart_tx, w_txd;
  logic O_sdram_clk, O_sdram_cke, O_sdram_cs_n, O_sdram_ras_n, O_sdram_cas_n, O_sdram_wen_n;
  logic [10:0] O_sdram_addr;
  logic [1:0]  O_sdram_ba;
  logic [3:0]  O_sdram_dqm;
  wire  [31:0] dq_unused;
  wire         sdcmd_unused;
  logic [5:0]  w_led;
  logic sdcard_pwr_n, sdclk, sddat1, sddat2, sddat3;
  logic MAX7219_CLK, MAX7219_DATA, MAX7219_LOAD;

  int total = 0;
  int bad   = 0;

  logic [7:0] banner [5] = '{8'h48, 8'h5A, 8'h33, 8'h0D, 8'h0A};
  logic [15:0] init_words [5] = '{16'h0F00, 16'h09FF, 16'h0A08, 16'h0B07, 16'h0C01};

  typedef struct {
    int          pulses;
    logic [5:0]  led;
    logic [15:0] d1;
    logic [15:0] d2;
  } row_t;
  row_t rows [5];

  hazard3_example_soc #(.UART_DIV(UDIV), .SPI_DIV(SDIV)) dut (
    .clk(clk), .rst(rst),
    .tck(1'b0), .trst_n(1'b1), .tms(1'b0), .tdi(1'b0), .tdo(tdo),
    .uart_rx(1'b1), .uart_tx(uart_tx), .w_rxd(1'b1), .w_txd(w_txd),
    .O_sdram_clk(O_sdram_clk), .O_sdram_cke(O_sdram_cke), .O_sdram_cs_n(O_sdram_cs_n),
    .O_sdram_ras_n(O_sdram_ras_n), .O_sdram_cas_n(O_sdram_cas_n), .O_sdram_wen_n(O_sdram_wen_n),
    .O_sdram_addr(O_sdram_addr), .O_sdram_ba(O_sdram_ba), .O_sdram_dqm(O_sdram_dqm),
    .IO_sdram_dq(dq_unused),
    .w_led(w_led), .w_btnl(w_btnl), .w_btnr(w_btnr),
    .sdcard_pwr_n(sdcard_pwr_n), .sdclk(sdclk), .sdcmd(sdcmd_unused), .sddat0(1'b0),
    .sddat1(sddat1), .sddat2(sddat2), .sddat3(sddat3),
    .MAX7219_CLK(MAX7219_CLK), .MAX7219_DATA(MAX7219_DATA), .MAX7219_LOAD(MAX7219_LOAD)
  );

  always #5 clk = ~clk;

  // MAX7219 receiver: shift on CLK rise while LOAD low, latch a full word on LOAD rise
  logic [15:0] spi_sh = '0;
  int          spi_nb = 0;
  logic [15:0] spi_q [$];
  always @(posedge MAX7219_CLK or posedge MAX7219_LOAD) begin
    if (MAX7219_LOAD) begin
      if (spi_nb == 16) spi_q.push_back(spi_sh);
      spi_nb = 0;
    end else begin
      spi_sh = {spi_sh[14:0], MAX7219_DATA};
      spi_nb++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected line level at banner cycle k (1-based)
  function automatic logic exp_tx(input int k);
    int idx;
    int p;
    logic [7:0] by;
    idx = k - 1;
    by  = banner[idx / (10 * UDIV)];
    p   = (idx % (10 * UDIV)) / UDIV;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p - 1];
  endfunction

  task automatic check_banner(input string tag);
    for (int k = 1; k <= int'(BANNER_CYC); k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_tx_c%0d", tag, k), 32'(uart_tx), 32'(exp_tx(k)));
      chk($sformatf("%s_txd_c%0d", tag, k), 32'(w_txd), 32'(exp_tx(k)));
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick(1);
      chk($sformatf("%s_idle%0d", tag, k), 32'(uart_tx), 32'd1);
    end
  endtask

  task automatic check_init(input string tag);
    logic [31:0] w;
    chk({tag, "_nwords"}, 32'(spi_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      w = 32'hFFFF_FFFF;
      if (i < spi_q.size()) w = {16'h0, spi_q[i]};
      chk($sformatf("%s_init%0d", tag, i), w, {16'h0, init_words[i]});
    end
  endtask

  task automatic check_consts(input string tag);
    chk({tag, "_pins"}, 32'({tdo, O_sdram_clk, O_sdram_cke, O_sdram_cs_n, O_sdram_ras_n,
                             O_sdram_cas_n, O_sdram_wen_n, sdcard_pwr_n, sdclk,
                             sddat1, sddat2, sddat3}), 32'h1F7);
    chk({tag, "_sdram_bus"}, 32'({O_sdram_addr, O_sdram_ba, O_sdram_dqm}), 32'h0000F);
  endtask

  task automatic pulse_l();
    w_btnl = 1'b1;
    tick(4);
    w_btnl = 1'b0;
    tick(4);
  endtask

  task automatic check_digits(input int r);
    logic [15:0] w;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] blank;
    tick(40);
    spi_q.delete();
    tick(LOOP_CYC + 40);
    d1 = 16'hFFFF;
    d2 = 16'hFFFF;
    blank = 16'hFFFF;
    foreach (spi_q[i]) begin
      w = spi_q[i];
      if (w[15:8] == 8'h01 && d1 == 16'hFFFF) d1 = w;
      if (w[15:8] == 8'h02 && d2 == 16'hFFFF) d2 = w;
      if (w[15:8] == 8'h05 && blank == 16'hFFFF) blank = w;
    end
    chk($sformatf("row%0d_digit1", r), 32'(d1), 32'(rows[r].d1));
    chk($sformatf("row%0d_digit2", r), 32'(d2), 32'(rows[r].d2));
    chk($sformatf("row%0d_digit5", r), 32'(blank), 32'h050F);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{3,  6'h3C, 16'h0103, 16'h020F};
    rows[1] = '{20, 6'h28, 16'h0103, 16'h0202};
    rows[2] = '{7,  6'h21, 16'h0100, 16'h0203};
    rows[3] = '{33, 6'h00, 16'h0103, 16'h0206};
    rows[4] = '{1,  6'h3F, 16'h0100, 16'h020F};

    // Reset state
    tick(5);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_txd", 32'(w_txd), 32'd1);
    chk("rst_led", 32'(w_led), 32'h3F);
    chk("rst_spi", 32'({MAX7219_CLK, MAX7219_DATA, MAX7219_LOAD}), 32'b001);
    check_consts("rst");

    // Boot banner and display init sequence
    spi_q.delete();
    rst = 1'b0;
    check_banner("boot");
    check_init("boot");
    check_idle("boot", 10);
    check_consts("boot");

    // Counter rows: LEDs and digit words (3+20+7+33+1 = 64 pulses wraps to 0)
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < rows[r].pulses; p++) pulse_l();
      chk($sformatf("row%0d_led", r), 32'(w_led), 32'(rows[r].led));
      check_digits(r);
    end

    // LED latency is three edges; a held button counts once
    w_btnl = 1'b1;
    tick(1);
    chk("lat_c1", 32'(w_led), 32'h3F);
    tick(1);
    chk("lat_c2", 32'(w_led), 32'h3F);
    tick(1);
    chk("lat_c3", 32'(w_led), 32'h3E);
    tick(20);
    chk("held", 32'(w_led), 32'h3E);
    w_btnl = 1'b0;
    tick(4);

    // Simultaneous btnl/btnr from idle: count and resend both happen
    w_btnl = 1'b1;
    w_btnr = 1'b1;
    tick(2);
    chk("sim_tx_c2", 32'(uart_tx), 32'd1);
    tick(1);
    chk("sim_led", 32'(w_led), 32'h3D);
    chk("sim_tx_c3", 32'(uart_tx), 32'd1);
    check_banner("sim");
    w_btnl = 1'b0;
    w_btnr = 1'b0;
    check_idle("sim", 20);

    // Two btnr presses mid-banner: banner completes, exactly one more follows
    w_btnr = 1'b1;
    tick(3);
    w_btnr = 1'b0;
    fork
      begin
        check_banner("mid_a");
        check_banner("mid_b");
      end
      begin
        tick(60);
        w_btnr = 1'b1;
        tick(4);
        w_btnr = 1'b0;
        tick(40);
        w_btnr = 1'b1;
        tick(4);
        w_btnr = 1'b0;
      end
    join
    check_idle("mid", 30);

    // Reset during the first start bit
    w_btnr = 1'b1;
    tick(3);
    w_btnr = 1'b0;
    tick(2);
    chk("pre_rst_tx", 32'(uart_tx), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_tx", 32'(uart_tx), 32'd1);
    chk("async_txd", 32'(w_txd), 32'd1);
    chk("async_led", 32'(w_led), 32'h3F);
    chk("async_spi", 32'({MAX7219_CLK, MAX7219_LOAD}), 32'b01);
    tick(3);
    spi_q.delete();
    rst = 1'b0;
    check_banner("rerun");
    check_init("rerun");
    check_consts("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
